// File: rtl/axi4_lite_read_arbiter_if.sv
// rtl/axi4_lite_read_arbiter_if.sv - AXI4-Lite read arbiter bus bundle
//
// Purpose: groups the upstream (per-requester AR/R) and downstream (single
// AR/R) read channel signals of axi4_lite_read_arbiter into one bundle.
//
// Signals (names carry the arbiter's own direction suffix):
//   req_read_address_i        NUM_REQ*ADDRESS_SIZE  packed upstream AR addresses
//   req_read_address_valid_i  NUM_REQ               upstream AR valid
//   req_read_address_ready_o  NUM_REQ               upstream AR ready
//   req_read_data_o           DATA_SIZE             R data broadcast upstream
//   req_read_data_response_o  2                     R response broadcast upstream
//   req_read_data_valid_o     NUM_REQ               R valid to granted requester
//   req_read_data_ready_i     NUM_REQ               upstream R ready
//   read_address_o            ADDRESS_SIZE          downstream AR address
//   read_address_valid_o      1                     downstream AR valid
//   read_address_ready_i      1                     downstream AR ready
//   read_data_i               DATA_SIZE             downstream R data
//   read_data_response_i      2                     downstream R response
//   read_data_valid_i         1                     downstream R valid
//   read_data_ready_o         1                     downstream R ready
//
// Modports: master = the arbiter's view, slave = the surrounding system's view.

interface axi4_lite_read_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
);

  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_read_address_i;
  logic [NUM_REQ-1:0]              req_read_address_valid_i;
  logic [NUM_REQ-1:0]              req_read_address_ready_o;
  logic [DATA_SIZE-1:0]            req_read_data_o;
  logic [1:0]                      req_read_data_response_o;
  logic [NUM_REQ-1:0]              req_read_data_valid_o;
  logic [NUM_REQ-1:0]              req_read_data_ready_i;
  logic [ADDRESS_SIZE-1:0]         read_address_o;
  logic                            read_address_valid_o;
  logic                            read_address_ready_i;
  logic [DATA_SIZE-1:0]            read_data_i;
  logic [1:0]                      read_data_response_i;
  logic                            read_data_valid_i;
  logic                            read_data_ready_o;

  modport master (
    input  req_read_address_i,
    input  req_read_address_valid_i,
    output req_read_address_ready_o,
    output req_read_data_o,
    output req_read_data_response_o,
    output req_read_data_valid_o,
    input  req_read_data_ready_i,
    output read_address_o,
    output read_address_valid_o,
    input  read_address_ready_i,
    input  read_data_i,
    input  read_data_response_i,
    input  read_data_valid_i,
    output read_data_ready_o
  );

  modport slave (
    output req_read_address_i,
    output req_read_address_valid_i,
    input  req_read_address_ready_o,
    input  req_read_data_o,
    input  req_read_data_response_o,
    input  req_read_data_valid_o,
    output req_read_data_ready_i,
    input  read_address_o,
    input  read_address_valid_o,
    output read_address_ready_i,
    output read_data_i,
    output read_data_response_i,
    output read_data_valid_i,
    input  read_data_ready_o
  );

endinterface

// File: rtl/axi4_lite_read_arbiter.sv
// rtl/axi4_lite_read_arbiter.sv - round-robin AXI4-Lite read arbiter, one outstanding read
//
// Purpose: shares one AXI4-Lite read subordinate between NUM_REQ read
// managers. An IDLE cycle picks a winner round-robin and accepts its AR,
// ADDR presents that AR downstream until accepted, DATA forwards the R beat
// to the winner. The pointer advances past the winner once its R completes.
//
// Ports:
//   clk_i       in   1        clock, rising edge
//   rst_clk_ni  in   1        asynchronous active-low reset
//   bus         master       upstream/downstream AR and R channels
//   grant_o     out  NUM_REQ  one-hot current owner, 0 in IDLE
//   busy_o      out  1        high while in ADDR or DATA

module axi4_lite_read_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_clk_ni,
  axi4_lite_read_arbiter_if.master bus,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [ADDRESS_SIZE-1:0] araddr_q, araddr_d;
  logic                    arvalid_q, arvalid_d;

  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [ADDRESS_SIZE-1:0] win_addr;

  logic [NUM_REQ-1:0]      arready_up;
  logic [NUM_REQ-1:0]      rvalid_up;
  logic [DATA_SIZE-1:0]    rdata_up;
  logic [1:0]              rresp_up;
  logic                    rready_dn;

  // Round-robin search: offset i from the pointer maps to requester
  // (ptr+i) mod NUM_REQ; the smallest offset with valid set wins.
  always_comb begin : arbitrate
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_found && (k == ((int'(ptr_q) + i) % NUM_REQ)) &&
            bus.req_read_address_valid_i[k]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(k);
          win_addr  = bus.req_read_address_i[k*ADDRESS_SIZE +: ADDRESS_SIZE];
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    arready_up = '0;
    rvalid_up  = '0;
    rdata_up   = '0;
    rresp_up   = 2'b00;
    rready_dn  = 1'b0;

    case (state_q)
      IDLE: begin
        // Gating on reset keeps the upstream ready low while reset is held,
        // even though the comb arbiter still sees valid requests.
        if (win_found && rst_clk_ni) begin
          arready_up[win_idx] = 1'b1;
          araddr_d            = win_addr;
          arvalid_d           = 1'b1;
          gidx_d              = win_idx;
          grant_d             = '0;
          grant_d[win_idx]    = 1'b1;
          state_d             = ADDR;
        end
      end

      ADDR: begin
        if (bus.read_address_ready_i) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end

      DATA: begin
        rvalid_up = grant_q & {NUM_REQ{bus.read_data_valid_i}};
        rdata_up  = bus.read_data_i;
        rresp_up  = bus.read_data_response_i;
        rready_dn = |(grant_q & bus.req_read_data_ready_i);
        if (bus.read_data_valid_i && rready_dn) begin
          ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_clk_ni) begin
    if (!rst_clk_ni) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      grant_q   <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      grant_q   <= grant_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
    end
  end

  assign bus.req_read_address_ready_o = arready_up;
  assign bus.req_read_data_valid_o    = rvalid_up;
  assign bus.req_read_data_o          = rdata_up;
  assign bus.req_read_data_response_o = rresp_up;
  assign bus.read_address_o           = araddr_q;
  assign bus.read_address_valid_o     = arvalid_q;
  assign bus.read_data_ready_o        = rready_dn;

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// tb/tb_axi4_lite_read_arbiter.sv - directed self-checking bench for axi4_lite_read_arbiter

module tb_axi4_lite_read_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;
  logic       busy;

  int vectors;
  int miscompares;
  int n0;
  int n1;

  axi4_lite_read_arbiter_if #(.NUM_REQ(2), .ADDRESS_SIZE(32), .DATA_SIZE(32)) bus ();

  axi4_lite_read_arbiter #(.NUM_REQ(2), .ADDRESS_SIZE(32), .DATA_SIZE(32)) dut (
    .clk_i      (clk),
    .rst_clk_ni (rst_n),
    .bus        (bus.master),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full no-wait-state read by requester r; expects 3 edges from upstream
  // AR handshake to completion. Entered and left at posedge+1 in IDLE.
  task automatic do_read(input int r, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] resp, input string tag);
    logic [1:0] oh;
    oh = 2'b01 << r;
    bus.req_read_address_i[r*32 +: 32] = a;
    bus.req_read_address_valid_i = oh;
    #1;
    chk({tag, ".ar_ready"}, bus.req_read_address_ready_o, oh);
    @(posedge clk); #1;
    bus.req_read_address_valid_i = 2'b00;
    chk({tag, ".grant"}, grant, oh);
    chk({tag, ".araddr"}, bus.read_address_o, a);
    chk({tag, ".arvalid"}, bus.read_address_valid_o, 1'b1);
    chk({tag, ".ready_in_addr"}, bus.req_read_address_ready_o, 2'b00);
    chk({tag, ".busy"}, busy, 1'b1);
    bus.read_address_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.read_address_ready_i = 1'b0;
    chk({tag, ".arvalid_clr"}, bus.read_address_valid_o, 1'b0);
    bus.read_data_i = d;
    bus.read_data_response_i = resp;
    bus.read_data_valid_i = 1'b1;
    bus.req_read_data_ready_i = oh;
    #1;
    chk({tag, ".rvalid"}, bus.req_read_data_valid_o, oh);
    chk({tag, ".rdata"}, bus.req_read_data_o, d);
    chk({tag, ".rresp"}, bus.req_read_data_response_o, resp);
    chk({tag, ".rready_dn"}, bus.read_data_ready_o, 1'b1);
    @(posedge clk); #1;
    bus.read_data_valid_i = 1'b0;
    bus.req_read_data_ready_i = 2'b00;
    chk({tag, ".grant_rel"}, grant, 2'b00);
    chk({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.req_read_address_i = {32'h0000_0200, 32'h0000_0100};
    bus.req_read_address_valid_i = 2'b11;
    bus.req_read_data_ready_i = 2'b00;
    bus.read_address_ready_i = 1'b0;
    bus.read_data_i = '0;
    bus.read_data_response_i = 2'b00;
    bus.read_data_valid_i = 1'b0;

    // Reset held with both valids high
    repeat (3) @(posedge clk);
    #1;
    chk("rst.grant", grant, 2'b00);
    chk("rst.arvalid", bus.read_address_valid_o, 1'b0);
    chk("rst.araddr", bus.read_address_o, 32'h0);
    chk("rst.ar_ready", bus.req_read_address_ready_o, 2'b00);
    chk("rst.rready_dn", bus.read_data_ready_o, 1'b0);
    chk("rst.rvalid", bus.req_read_data_valid_o, 2'b00);
    chk("rst.busy", busy, 1'b0);

    // Release: requester 0 has priority
    rst_n = 1'b1;
    #1;
    chk("rel.ar_ready", bus.req_read_address_ready_o, 2'b01);
    @(posedge clk); #1;
    bus.req_read_address_valid_i = 2'b00;
    chk("rel.grant", grant, 2'b01);
    chk("rel.araddr", bus.read_address_o, 32'h0000_0100);
    bus.read_address_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.read_address_ready_i = 1'b0;
    bus.read_data_i = 32'h1111_0000;
    bus.read_data_valid_i = 1'b1;
    bus.req_read_data_ready_i = 2'b01;
    #1;
    chk("rel.rvalid", bus.req_read_data_valid_o, 2'b01);
    @(posedge clk); #1;
    bus.read_data_valid_i = 1'b0;
    bus.req_read_data_ready_i = 2'b00;
    chk("rel.grant_rel", grant, 2'b00);

    // Single read and error passthrough, both by requester 1
    do_read(1, 32'h0000_0000, 32'hCAFE_0001, 2'b00, "single");
    do_read(1, 32'h0000_0004, 32'h0000_0000, 2'b10, "slverr");

    // Contention: pointer is 0 here, so winners go 0,1,0,1,...
    bus.req_read_address_i = {32'h0000_0200, 32'h0000_0100};
    bus.req_read_address_valid_i = 2'b11;
    bus.read_address_ready_i = 1'b1;
    bus.read_data_valid_i = 1'b1;
    bus.read_data_i = 32'h5A5A_0000;
    bus.req_read_data_ready_i = 2'b11;
    n0 = 0;
    n1 = 0;
    for (int t = 0; t < 8; t++) begin
      logic [1:0] exp_oh;
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("cont.ar_ready", bus.req_read_address_ready_o, exp_oh);
      chk("cont.rready_idle", bus.read_data_ready_o, 1'b0);
      @(posedge clk); #1;
      chk("cont.grant", grant, exp_oh);
      chk("cont.araddr", bus.read_address_o, (t % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      if (grant == 2'b01) n0++;
      if (grant == 2'b10) n1++;
      @(posedge clk); #1;
      chk("cont.rvalid", bus.req_read_data_valid_o, exp_oh);
      @(posedge clk);
    end
    #1;
    bus.req_read_address_valid_i = 2'b00;
    bus.read_address_ready_i = 1'b0;
    bus.read_data_valid_i = 1'b0;
    bus.req_read_data_ready_i = 2'b00;
    chk("cont.n0", n0, 4);
    chk("cont.n1", n1, 4);

    // AR backpressure by requester 0 (pointer back at 0)
    bus.req_read_address_i[31:0] = 32'hA5A5_0000;
    bus.req_read_address_valid_i = 2'b01;
    @(posedge clk); #1;
    bus.req_read_address_valid_i = 2'b00;
    for (int c = 0; c < 5; c++) begin
      chk("arbp.araddr", bus.read_address_o, 32'hA5A5_0000);
      chk("arbp.arvalid", bus.read_address_valid_o, 1'b1);
      @(posedge clk); #1;
    end
    bus.read_address_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.read_address_ready_i = 1'b0;
    chk("arbp.arvalid_clr", bus.read_address_valid_o, 1'b0);
    bus.read_data_i = 32'h0BAD_0000;
    bus.read_data_valid_i = 1'b1;
    bus.req_read_data_ready_i = 2'b01;
    @(posedge clk); #1;
    bus.read_data_valid_i = 1'b0;
    bus.req_read_data_ready_i = 2'b00;
    chk("arbp.grant_rel", grant, 2'b00);

    // R backpressure by requester 1 (pointer now 1)
    bus.req_read_address_i[63:32] = 32'h0000_0300;
    bus.req_read_address_valid_i = 2'b10;
    bus.read_address_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_read_address_valid_i = 2'b00;
    @(posedge clk); #1;
    bus.read_address_ready_i = 1'b0;
    bus.read_data_i = 32'h1234_5678;
    bus.read_data_valid_i = 1'b1;
    bus.req_read_data_ready_i = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rbp.rready_dn", bus.read_data_ready_o, 1'b0);
      chk("rbp.rvalid", bus.req_read_data_valid_o, 2'b10);
      chk("rbp.grant", grant, 2'b10);
      @(posedge clk); #1;
    end
    bus.req_read_data_ready_i = 2'b10;
    #1;
    chk("rbp.rready_go", bus.read_data_ready_o, 1'b1);
    @(posedge clk); #1;
    bus.read_data_valid_i = 1'b0;
    bus.req_read_data_ready_i = 2'b00;
    chk("rbp.grant_rel", grant, 2'b00);

    // Async reset while R is pending in DATA
    bus.req_read_address_i[31:0] = 32'h0000_0040;
    bus.req_read_address_valid_i = 2'b01;
    bus.read_address_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.req_read_address_valid_i = 2'b00;
    @(posedge clk); #1;
    bus.read_address_ready_i = 1'b0;
    bus.read_data_i = 32'hDEAD_BEEF;
    bus.read_data_valid_i = 1'b1;
    #1;
    chk("arst.pre_grant", grant, 2'b01);
    chk("arst.pre_rvalid", bus.req_read_data_valid_o, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("arst.grant", grant, 2'b00);
    chk("arst.rvalid", bus.req_read_data_valid_o, 2'b00);
    chk("arst.rdata", bus.req_read_data_o, 32'h0);
    chk("arst.rready_dn", bus.read_data_ready_o, 1'b0);
    chk("arst.busy", busy, 1'b0);
    chk("arst.araddr", bus.read_address_o, 32'h0);
    bus.read_data_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(0, 32'h0000_0044, 32'h600D_F00D, 2'b00, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
